// File: rtl/aos_cfg_fifo_pkg.sv
// Shared types and helpers for the configurable AmorphOS queue FIFO.
// Stats width applies only when AOS_FIFO_STATS_EN is defined.
package aos_fifo_pkg;

  typedef enum logic {
    AOS_FIFO_FALLTHRU = 1'b0,
    AOS_FIFO_REGOUT   = 1'b1
  } aos_fifo_type_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } aos_out_state_e;

  localparam int AOS_FIFO_STAT_W = 16;

  function automatic int aos_fifo_capacity(
    input int typ,
    input int depth_log2
  );
    int extra;
    extra = (typ == int'(AOS_FIFO_REGOUT)) ? 1 : 0;
    return (1 << depth_log2) + extra;
  endfunction

endpackage

// File: rtl/aos_cfg_fifo_if.sv
// Enqueue/dequeue bundle for aos_cfg_fifo.
// Stats signals exist only when AOS_FIFO_STATS_EN is defined.
interface aos_cfg_fifo_if
  import aos_fifo_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 2
) ();

  logic                  enq_en;
  logic [WIDTH-1:0]      enq_data;
  logic                  full;
  logic                  almost_full;
  logic                  deq_en;
  logic [WIDTH-1:0]      deq_data;
  logic                  empty;
  logic [DEPTH_LOG2:0]   count;
`ifdef AOS_FIFO_STATS_EN
  logic [DEPTH_LOG2:0]          hw_mark;
  logic [AOS_FIFO_STAT_W-1:0]   ovf_cnt;
  logic [AOS_FIFO_STAT_W-1:0]   udf_cnt;

  modport slave (
    input  enq_en, enq_data, deq_en,
    output full, almost_full, deq_data,
    output empty, count,
    output hw_mark, ovf_cnt, udf_cnt
  );

  modport master (
    output enq_en, enq_data, deq_en,
    input  full, almost_full, deq_data,
    input  empty, count,
    input  hw_mark, ovf_cnt, udf_cnt
  );
`else
  modport slave (
    input  enq_en, enq_data, deq_en,
    output full, almost_full, deq_data,
    output empty, count
  );

  modport master (
    output enq_en, enq_data, deq_en,
    input  full, almost_full, deq_data,
    input  empty, count
  );
`endif

endinterface

// File: rtl/aos_cfg_fifo_ram.sv
// Storage array: one write port, async read (fall-through)
// or registered read that doubles as the output stage.
module aos_fifo_ram #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 2,
  parameter bit SYNC_RD    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  if (SYNC_RD) begin : g_sync
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Holds the last head when no reload happens.
    always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
  end else begin : g_async
    logic unused_ok;
    assign unused_ok = ^{re, rst_n};
    assign rdata     = mem_q[raddr];
  end

endmodule

// File: rtl/aos_cfg_fifo.sv
// Configurable single-clock FIFO: fall-through or registered output.
// Optional stats outputs under AOS_FIFO_STATS_EN.
module aos_cfg_fifo
  import aos_fifo_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 2,
  parameter int TYPE       = 0,
  parameter int AF_THRESH  = (2**DEPTH_LOG2) - 1
) (
  input logic         clk,
  input logic         rst_n,
  aos_cfg_fifo_if.slave io
);

  localparam int CW     = DEPTH_LOG2 + 1;
  localparam int CAP    = aos_fifo_capacity(TYPE, DEPTH_LOG2);
  localparam bit REGOUT = (TYPE == int'(AOS_FIFO_REGOUT));
  localparam logic [CW-1:0] CAP_C = CW'(CAP);
  localparam logic [CW-1:0] AF_C  = CW'(AF_THRESH);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  af_q, af_d;
  aos_out_state_e        state_q, state_d;
  logic                  push, pop, ram_re;

  always_comb begin
    push    = io.enq_en && !full_q;
    pop     = io.deq_en && !empty_q;
    ram_re  = pop;
    state_d = state_q;
    if (REGOUT) begin
      // Reload on pop so back-to-back pops see no bubble.
      ram_re = (ram_cnt_q != '0) &&
               ((state_q == OUT_EMPTY) || pop);
      unique case (state_q)
        OUT_EMPTY: if (ram_cnt_q != '0) state_d = OUT_VALID;
        OUT_VALID: if (pop && ram_cnt_q == '0) state_d = OUT_EMPTY;
        default:   state_d = OUT_EMPTY;
      endcase
    end
    wr_ptr_d  = wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d  = rd_ptr_q + DEPTH_LOG2'(ram_re);
    ram_cnt_d = ram_cnt_q + CW'(push) - CW'(ram_re);
    count_d   = count_q + CW'(push) - CW'(pop);
    empty_d   = REGOUT ? (state_d == OUT_EMPTY)
                       : (count_d == '0);
    full_d    = (count_d == CAP_C);
    af_d      = (count_d >= AF_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      state_q   <= OUT_EMPTY;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      af_q      <= af_d;
      state_q   <= state_d;
    end
  end

  aos_fifo_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .SYNC_RD    (REGOUT)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (io.enq_data),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (io.deq_data)
  );

  assign io.full        = full_q;
  assign io.almost_full = af_q;
  assign io.empty       = empty_q;
  assign io.count       = count_q;

`ifdef AOS_FIFO_STATS_EN
  logic [CW-1:0]              hw_q, hw_d;
  logic [AOS_FIFO_STAT_W-1:0] ovf_q, ovf_d;
  logic [AOS_FIFO_STAT_W-1:0] udf_q, udf_d;

  always_comb begin
    hw_d  = (count_d > hw_q) ? count_d : hw_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (io.enq_en && full_q && ovf_q != '1)
      ovf_d = ovf_q + 1'b1;
    if (io.deq_en && empty_q && udf_q != '1)
      udf_d = udf_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_q  <= '0;
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      hw_q  <= hw_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign io.hw_mark = hw_q;
  assign io.ovf_cnt = ovf_q;
  assign io.udf_cnt = udf_q;
`endif

endmodule

// File: tb/tb_aos_cfg_fifo.sv
// Bench for aos_cfg_fifo: fall-through and registered-output
// instances driven in lockstep against queue scoreboards.
module tb_aos_cfg_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  aos_cfg_fifo_if #(.WIDTH(8), .DEPTH_LOG2(2)) i0 ();
  aos_cfg_fifo_if #(.WIDTH(8), .DEPTH_LOG2(2)) i1 ();

  aos_cfg_fifo #(
    .WIDTH(8), .DEPTH_LOG2(2), .TYPE(0)
  ) u0 (.clk(clk), .rst_n(rst_n), .io(i0));

  aos_cfg_fifo #(
    .WIDTH(8), .DEPTH_LOG2(2), .TYPE(1)
  ) u1 (.clk(clk), .rst_n(rst_n), .io(i1));

  typedef struct {
    int         e;
    logic [7:0] d;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  int cyc = 0;
  int lp1 = 0;
  int checks = 0;
  int errors = 0;
  int hw0 = 0, hw1 = 0;
  int ov0 = 0, ov1 = 0;
  int ud0 = 0, ud1 = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit emp0();
    return q0.size() == 0;
  endfunction

  // Head of the registered variant shows one edge after its
  // push, or on the edge that popped its predecessor.
  function automatic bit emp1();
    int v;
    if (q1.size() == 0) return 1'b1;
    v = q1[0].e + 1;
    if (lp1 > v) v = lp1;
    return cyc < v;
  endfunction

  task automatic check_all();
    chk("cnt0", 32'(i0.count), q0.size());
    chk("emp0", 32'(i0.empty), 32'(emp0()));
    chk("full0", 32'(i0.full), 32'(q0.size() == 4));
    chk("af0", 32'(i0.almost_full), 32'(q0.size() >= 3));
    if (!emp0()) chk("data0", 32'(i0.deq_data), 32'(q0[0].d));
    chk("cnt1", 32'(i1.count), q1.size());
    chk("emp1", 32'(i1.empty), 32'(emp1()));
    chk("full1", 32'(i1.full), 32'(q1.size() == 5));
    chk("af1", 32'(i1.almost_full), 32'(q1.size() >= 3));
    if (!emp1()) chk("data1", 32'(i1.deq_data), 32'(q1[0].d));
`ifdef AOS_FIFO_STATS_EN
    chk("hw0", 32'(i0.hw_mark), hw0);
    chk("ovf0", 32'(i0.ovf_cnt), ov0);
    chk("udf0", 32'(i0.udf_cnt), ud0);
    chk("hw1", 32'(i1.hw_mark), hw1);
    chk("ovf1", 32'(i1.ovf_cnt), ov1);
    chk("udf1", 32'(i1.udf_cnt), ud1);
`endif
  endtask

  task automatic cycle(input logic pe,
                       input logic [7:0] pd,
                       input logic de);
    bit a0p, a0d, a1p, a1d;
    i0.enq_en = pe; i0.enq_data = pd; i0.deq_en = de;
    i1.enq_en = pe; i1.enq_data = pd; i1.deq_en = de;
    a0p = pe && (q0.size() < 4);
    a0d = de && !emp0();
    a1p = pe && (q1.size() < 5);
    a1d = de && !emp1();
    if (pe && !a0p && ov0 < 65535) ov0++;
    if (de && !a0d && ud0 < 65535) ud0++;
    if (pe && !a1p && ov1 < 65535) ov1++;
    if (de && !a1d && ud1 < 65535) ud1++;
    @(posedge clk);
    cyc++;
    #1;
    if (a0d) void'(q0.pop_front());
    if (a0p) q0.push_back(ent_t'{e: cyc, d: pd});
    if (a1d) begin
      void'(q1.pop_front());
      lp1 = cyc;
    end
    if (a1p) q1.push_back(ent_t'{e: cyc, d: pd});
    if (q0.size() > hw0) hw0 = q0.size();
    if (q1.size() > hw1) hw1 = q1.size();
    i0.enq_en = 1'b0; i0.deq_en = 1'b0;
    i1.enq_en = 1'b0; i1.deq_en = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    i0.enq_en = 1'b0; i0.deq_en = 1'b0; i0.enq_data = '0;
    i1.enq_en = 1'b0; i1.deq_en = 1'b0; i1.enq_data = '0;
    rst_n = 1'b0;
    #2;
    q0.delete();
    q1.delete();
    lp1 = 0;
    hw0 = 0; hw1 = 0;
    ov0 = 0; ov1 = 0;
    ud0 = 0; ud1 = 0;
    check_all();
    chk("rst_out1", 32'(i1.deq_data), 0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    cycle(1'b1, 8'hA1, 1'b0);
    chk("t0_a1", 32'(i0.deq_data), 32'h00A1);
    chk("t1_lat", 32'(i1.empty), 1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("t1_a1", 32'(i1.deq_data), 32'h00A1);
    cycle(1'b0, 8'h00, 1'b1);

    cycle(1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 8'hB0 + 8'(i), 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    chk("t0_full", 32'(i0.full), 1);
    chk("t0_cnt", 32'(i0.count), 4);
    chk("t1_full", 32'(i1.full), 1);
    chk("t1_cnt", 32'(i1.count), 5);
    repeat (7) cycle(1'b0, 8'h00, 1'b1);
    chk("t0_drain", 32'(i0.empty), 1);
    chk("t1_drain", 32'(i1.empty), 1);

    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h33, 1'b1);
    chk("sim0_c2", 32'(i0.count), 2);
    chk("sim1_c2", 32'(i1.count), 2);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h44, 1'b1);
    chk("sim0_c1", 32'(i0.count), 1);
    chk("sim1_c1", 32'(i1.count), 1);
    repeat (2) cycle(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 10; i++)
      cycle(1'b1, 8'h50 + 8'(i), 1'b1);
    repeat (4) cycle(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 99) < 55),
            8'($urandom),
            1'($urandom_range(0, 99) < 50));

`ifdef AOS_FIFO_STATS_EN
    do_reset();
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 8'h70 + 8'(i), 1'b0);
    chk("st_ovf1", 32'(i1.ovf_cnt), 3);
    chk("st_hw1", 32'(i1.hw_mark), 5);
    repeat (7) cycle(1'b0, 8'h00, 1'b1);
    chk("st_udf1", 32'(i1.udf_cnt), 2);
`endif

    for (int i = 0; i < 3; i++)
      cycle(1'b1, 8'hC0 + 8'(i), 1'b0);
    do_reset();
    chk("mid_cnt0", 32'(i0.count), 0);
    chk("mid_cnt1", 32'(i1.count), 0);
`ifdef AOS_FIFO_STATS_EN
    chk("mid_hw1", 32'(i1.hw_mark), 0);
    chk("mid_ovf1", 32'(i1.ovf_cnt), 0);
`endif
    repeat (4) cycle(1'b1, 8'h5A, 1'b1);
    repeat (4) cycle(1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
